quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
Receiver for two-phase quadrature step signals (qa/qb) from a rotary encoder or pulse source. It synchronises the phases, decodes each legal Gray-code transition into an up or down step, and maintains a position count on led. It also flags illegal double transitions. It sits between the board phase inputs and the LED/position logic, running on clkpulse.

Parameters:
WIDTH, 4, position counter width (led width)
SYNC_STAGES, 2, flip-flop synchroniser depth on qa/qb (legal values 2-4)
WRAP, 1, 1 = position wraps modulo 2^WIDTH; 0 = saturates at 0 and 2^WIDTH-1
FILT_LEN, 3, consecutive stable samples required by the glitch filter (used only with QDEC_FILTER_EN)

Ports:
clkpulse  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
qa  input  1  phase A, asynchronous to clkpulse
qb  input  1  phase B, asynchronous to clkpulse
en  input  1  1 = count decoded steps; 0 = track phase but do not count
clr_err  input  1  synchronous clear of the sticky err flag
led  output  WIDTH  current position count
step  output  1  one-cycle pulse when led changes
dir  output  1  direction of the last decoded legal transition (1 = up, 0 = down)
err  output  1  sticky flag for an illegal transition

Behaviour:
- Reset (async, rst=1): led=0, step=0, dir=0, err=0, synchroniser and filter registers=0, prev=00, FSM=INIT.
- Sampled state s={qa_sync,qb_sync}, taken after the synchroniser, plus the filter when that feature is enabled.
- FSM INIT: lasts SYNC_STAGES cycles after rst deasserts, flushing the synchroniser. No counting and no err during INIT. On exit, prev<=s and FSM goes to TRACK. No step is generated for the initial phase value.
- FSM TRACK, each cycle compares s to prev:
  - s==prev: no event.
  - Up sequence (00->01->11->10->00): dir<=1. If en=1, led+1 and step=1.
  - Down sequence (reverse): dir<=0. If en=1, led-1 and step=1.
  - Both bits changed (00<->11, 01<->10): err<=1. led and dir unchanged, no step.
  - prev<=s in all cases, including when en=0 and on an error.
- Decoding is x4: one count per legal edge.
- Width and wrap:
  - WRAP=1: arithmetic modulo 2^WIDTH (4'hF+1=0, 0-1=4'hF).
  - WRAP=0: hold at the limit. A step that would pass a limit gives no led change and no step pulse, but dir still updates.
- Latency without filter: the value on qa/qb, stable before edge k, appears in s after edge k+SYNC_STAGES-1. led and step update at edge k+SYNC_STAGES, which is the 3rd rising edge for the default.
- step is high for exactly one cycle per counted transition. Back-to-back legal transitions on consecutive cycles give consecutive step pulses.
- clr_err=1 clears err on the next edge. If clr_err coincides with a new illegal transition, err stays 1 (set wins).
- rst asserted mid-operation: all outputs clear immediately (asynchronously). After release the block re-enters INIT.

Optional Feature:
QDEC_FILTER_EN.
- Defined: each synchronised phase passes through a per-bit filter. The filtered bit changes only after the raw synchronised bit has held its new value for FILT_LEN consecutive cycles. Shorter glitches are discarded. Latency grows by FILT_LEN cycles. INIT also waits FILT_LEN further cycles before loading prev.
- Undefined: no filter logic is generated, s comes directly from the synchroniser, and FILT_LEN is ignored.

Test Plan:
- Reset, then hold qa=1,qb=0 through INIT -> led=0, no step, err=0; prev captured as 10.
- From 00, apply 01,11,10,00 with each phase held 4 cycles, en=1 -> led 0->4, four single-cycle step pulses, dir=1; each led update occurs 3 edges after the phase change.
- From led=4'h1 (WRAP=1), apply the reverse sequence for 3 steps -> led 1,0,F,E; dir=0. With WRAP=0, the same stimulus gives led 1,0,0,0 and only one step pulse.
- Jump 00->11 -> err=1, led unchanged, no step. Pulse clr_err in the same cycle as a second 01->10 error -> err remains 1. Pulse clr_err alone -> err=0 next cycle.
- en=0 during 4 up transitions, then en=1 and 1 up transition -> led increments by exactly 1 with no spurious count.
- Assert rst mid-sequence at led=7 -> led=0 immediately. With QDEC_FILTER_EN and FILT_LEN=3, a 2-cycle glitch on qa -> no count; a 3-cycle stable change -> one count.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises qa/qb, decodes x4 Gray transitions into a position count.
// Optional glitch filter on the synchronised phases is enabled with `define QDEC_FILTER_EN.
module quad_step_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WRAP        = 1,
  parameter int FILT_LEN    = 3
) (
  input  logic             clkpulse,
  input  logic             rst,
  input  logic             qa,
  input  logic             qb,
  input  logic             en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             dir,
  output logic             err
);

`ifdef QDEC_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  // INIT must also flush the filter so prev is loaded with a settled phase value.
  localparam int INIT_LEN = SYNC_STAGES + (FILT_EN ? FILT_LEN : 0);
  localparam int CNT_W    = $clog2(INIT_LEN + 1);

  typedef enum logic {INIT, TRACK} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [1:0]             prev, prev_nxt;
  logic [WIDTH-1:0]       led_nxt;
  logic                   step_nxt, dir_nxt, err_nxt;
  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             raw, s, diff;
  logic [WIDTH:0]         up_res, dn_res;

  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Returns {moved, new_position}; moved=0 when saturation holds the count.
  function automatic logic [WIDTH:0] next_pos(input logic [WIDTH-1:0] pos, input logic up);
    logic [WIDTH-1:0] nxt;
    logic             at_lim;
    nxt    = up ? pos + 1'b1 : pos - 1'b1;
    at_lim = up ? (pos == {WIDTH{1'b1}}) : (pos == '0);
    if (WRAP == 0 && at_lim) return {1'b0, pos};
    return {1'b1, nxt};
  endfunction

  // Stage: synchroniser
  always_ff @(posedge clkpulse or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], qa};
      sync_b <= {sync_b[SYNC_STAGES-2:0], qb};
    end
  end

  assign raw = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

`ifdef QDEC_FILTER_EN
  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FC_W-1:0] fcnt [2];
  logic [1:0]      filt;

  // Stage: per-bit glitch filter
  always_ff @(posedge clkpulse or posedge rst) begin
    if (rst) begin
      filt    <= '0;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FC_W'(FILT_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign s = filt;
`else
  assign s = raw;
`endif

  // Stage: transition decode and position update
  assign diff   = gray_idx(s) - gray_idx(prev);
  assign up_res = next_pos(led, 1'b1);
  assign dn_res = next_pos(led, 1'b0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prev_nxt  = prev;
    led_nxt   = led;
    step_nxt  = 1'b0;
    dir_nxt   = dir;
    err_nxt   = err & ~clr_err;
    case (state)
      INIT: begin
        if (cnt == CNT_W'(INIT_LEN)) begin
          prev_nxt  = s;
          state_nxt = TRACK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TRACK: begin
        prev_nxt = s;
        case (diff)
          2'd1: begin
            dir_nxt = 1'b1;
            if (en && up_res[WIDTH]) begin
              led_nxt  = up_res[WIDTH-1:0];
              step_nxt = 1'b1;
            end
          end
          2'd3: begin
            dir_nxt = 1'b0;
            if (en && dn_res[WIDTH]) begin
              led_nxt  = dn_res[WIDTH-1:0];
              step_nxt = 1'b1;
            end
          end
          2'd2:    err_nxt = 1'b1;
          default: ;
        endcase
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clkpulse or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      prev  <= 2'b00;
      led   <= '0;
      step  <= 1'b0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= prev_nxt;
      led   <= led_nxt;
      step  <= step_nxt;
      dir   <= dir_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: a wrapping and a saturating instance share stimulus.
module tb_quad_step_decoder;

`ifdef QDEC_FILTER_EN
  localparam int FLAT = 3;
`else
  localparam int FLAT = 0;
`endif
  localparam int LAT  = 3 + FLAT;
  localparam int HOLD = LAT + 1;

  logic       clkpulse, rst, qa, qb, en, clr_err;
  logic [3:0] led_w, led_s;
  logic       step_w, step_s, dir_w, dir_s, err_w, err_s;

  quad_step_decoder #(.WIDTH(4), .SYNC_STAGES(2), .WRAP(1), .FILT_LEN(3)) u_wrap (
    .clkpulse(clkpulse), .rst(rst), .qa(qa), .qb(qb), .en(en), .clr_err(clr_err),
    .led(led_w), .step(step_w), .dir(dir_w), .err(err_w));

  quad_step_decoder #(.WIDTH(4), .SYNC_STAGES(2), .WRAP(0), .FILT_LEN(3)) u_sat (
    .clkpulse(clkpulse), .rst(rst), .qa(qa), .qb(qb), .en(en), .clr_err(clr_err),
    .led(led_s), .step(step_s), .dir(dir_s), .err(err_s));

  initial clkpulse = 1'b0;
  always #5 clkpulse = ~clkpulse;

  typedef struct {
    logic [3:0] led;
    logic       dir;
    int         at;
  } exp_t;

  exp_t qw[$];
  exp_t qs[$];
  exp_t ew, es;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clkpulse) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every step pulse consumes one expected event
  always @(negedge clkpulse) begin
    if (!rst) begin
      if (step_w) begin
        if (qw.size() == 0) check("wrap_spurious_step", 1, 0);
        else begin
          ew = qw.pop_front();
          check("wrap_led", led_w, ew.led);
          check("wrap_dir", dir_w, ew.dir);
          check("wrap_step_cycle", cyc, ew.at);
        end
      end
      if (step_s) begin
        if (qs.size() == 0) check("sat_spurious_step", 1, 0);
        else begin
          es = qs.pop_front();
          check("sat_led", led_s, es.led);
          check("sat_dir", dir_s, es.dir);
          check("sat_step_cycle", cyc, es.at);
        end
      end
    end
  end

  // Drive a phase at a falling edge; pw/ps say whether each instance must pulse step.
  task automatic apply(input logic a, input logic b,
                       input logic pw, input logic [3:0] lw,
                       input logic ps, input logic [3:0] ls, input logic d);
    qa = a;
    qb = b;
    if (pw) qw.push_back('{lw, d, cyc + LAT});
    if (ps) qs.push_back('{ls, d, cyc + LAT});
    repeat (HOLD) @(negedge clkpulse);
    check("wrap_dir_hold", dir_w, d);
    check("sat_dir_hold", dir_s, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; qa = 1'b1; qb = 1'b0; en = 1'b1; clr_err = 1'b0;
    repeat (2) @(negedge clkpulse);
    check("rst_led_w", led_w, 0);
    check("rst_led_s", led_s, 0);
    check("rst_step", step_w, 0);
    check("rst_dir", dir_w, 0);
    check("rst_err", err_w, 0);
    rst = 1'b0;
    repeat (10) @(negedge clkpulse);
    check("init_led", led_w, 0);
    check("init_err", err_w, 0);
    check("init_dir", dir_w, 0);

    // 10->00 is an up edge but en=0: prev/dir track, no count
    en = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 1);
    en = 1'b1;
    apply(0, 1, 1, 4'h1, 1, 4'h1, 1);
    apply(1, 1, 1, 4'h2, 1, 4'h2, 1);
    apply(1, 0, 1, 4'h3, 1, 4'h3, 1);
    apply(0, 0, 1, 4'h4, 1, 4'h4, 1);

    // Down through zero: wrap goes F,E; saturating holds at 0
    apply(1, 0, 1, 4'h3, 1, 4'h3, 0);
    apply(1, 1, 1, 4'h2, 1, 4'h2, 0);
    apply(0, 1, 1, 4'h1, 1, 4'h1, 0);
    apply(0, 0, 1, 4'h0, 1, 4'h0, 0);
    apply(1, 0, 1, 4'hF, 0, 4'h0, 0);
    apply(1, 1, 1, 4'hE, 0, 4'h0, 0);
    check("sat_floor_led", led_s, 4'h0);

    // Up through F -> 0
    apply(1, 0, 1, 4'hF, 1, 4'h1, 1);
    apply(0, 0, 1, 4'h0, 1, 4'h2, 1);

    // Illegal 00->11
    apply(1, 1, 0, 0, 0, 0, 1);
    check("err_set_w", err_w, 1);
    check("err_set_s", err_s, 1);
    check("err_led_w", led_w, 4'h0);
    apply(0, 1, 1, 4'hF, 1, 4'h1, 0);
    check("err_sticky", err_w, 1);

    // Illegal 01->10 with clr_err on the same edge: set wins
    qa = 1'b1; qb = 1'b0;
    repeat (LAT - 1) @(negedge clkpulse);
    clr_err = 1'b1;
    @(negedge clkpulse);
    clr_err = 1'b0;
    check("err_set_wins_w", err_w, 1);
    check("err_set_wins_s", err_s, 1);
    repeat (HOLD) @(negedge clkpulse);
    clr_err = 1'b1;
    @(negedge clkpulse);
    clr_err = 1'b0;
    check("err_clear_w", err_w, 0);
    check("err_clear_s", err_s, 0);

    // Four ups with en=0, then one counted up
    en = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 1);
    apply(0, 1, 0, 0, 0, 0, 1);
    apply(1, 1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 0, 1);
    en = 1'b1;
    apply(0, 0, 1, 4'h0, 1, 4'h2, 1);

    // Climb to 7, then async reset mid-operation
    apply(0, 1, 1, 4'h1, 1, 4'h3, 1);
    apply(1, 1, 1, 4'h2, 1, 4'h4, 1);
    apply(1, 0, 1, 4'h3, 1, 4'h5, 1);
    apply(0, 0, 1, 4'h4, 1, 4'h6, 1);
    apply(0, 1, 1, 4'h5, 1, 4'h7, 1);
    apply(1, 1, 1, 4'h6, 1, 4'h8, 1);
    apply(1, 0, 1, 4'h7, 1, 4'h9, 1);
    check("pre_rst_led", led_w, 4'h7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led_w", led_w, 4'h0);
    check("async_rst_led_s", led_s, 4'h0);
    check("async_rst_dir", dir_w, 0);
    @(negedge clkpulse);
    rst = 1'b0;
    repeat (10) @(negedge clkpulse);
    check("reinit_led", led_w, 4'h0);

`ifdef QDEC_FILTER_EN
    apply(0, 0, 1, 4'h1, 1, 4'h1, 1);
    // Two-cycle glitch on qa is rejected
    qa = 1'b1;
    repeat (2) @(negedge clkpulse);
    qa = 1'b0;
    repeat (HOLD) @(negedge clkpulse);
    check("glitch_led", led_w, 4'h1);
    // Held change counts once (00->10 is down)
    apply(1, 0, 1, 4'h0, 1, 4'h0, 0);
`endif

    repeat (5) @(negedge clkpulse);
    check("wrap_missing_steps", qw.size(), 0);
    check("sat_missing_steps", qs.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
